// File: rtl/instr_fetch_queue.sv
// Fetch stage: req/ack instruction fetch into a DEPTH-entry prefetch FIFO, with redirect flush and HALT stop.
// Build option: define FETCH_BRANCH_FOLLOW_EN to follow unconditional branches (opcode 0011, cc 0000) at fetch.
module instr_fetch_queue #(
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   instr_valid,
  output logic [31:0]            instr_data,
  output logic [ADDR_W-1:0]      instr_pc,
  input  logic                   instr_ready,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] q_count,
  output logic [1:0]             dbg_state
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] OP_HALT = 4'b1000;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HALT = 2'd2} state_e;

  state_e state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              discard_q, discard_d;
  logic              halted_q, halted_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       q_data_q [DEPTH];
  logic [31:0]       q_data_d [DEPTH];
  logic [ADDR_W-1:0] q_pc_q [DEPTH];
  logic [ADDR_W-1:0] q_pc_d [DEPTH];

  logic              ack_take, is_halt_word, push, pop, can_issue;
  logic [ADDR_W-1:0] next_fetch_pc;

  // Handshakes: memory transfers a word in the cycle mem_req && mem_ack; the decoder
  // consumes the head in the cycle instr_valid && instr_ready. Redirect overrides both.
  assign ack_take     = (state_q == S_WAIT) && mem_ack;
  assign is_halt_word = (mem_rdata[31:28] == OP_HALT);
  assign push         = ack_take && !discard_q && !redirect;
  assign pop          = (count_q != '0) && instr_ready && !redirect;
  // A slot is reserved at issue time, so the eventual push can never overflow.
  assign can_issue    = (state_q == S_IDLE) && !redirect && (count_q < CNT_W'(DEPTH));

  always_comb begin
    next_fetch_pc = mem_addr_q + ADDR_W'(1);
`ifdef FETCH_BRANCH_FOLLOW_EN
    if (mem_rdata[31:28] == 4'b0011 && mem_rdata[27:24] == 4'b0000)
      next_fetch_pc = mem_rdata[ADDR_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (can_issue) state_d = S_WAIT;
      S_WAIT: begin
        if (redirect)     state_d = mem_ack ? S_IDLE : S_WAIT;
        else if (mem_ack) state_d = (!discard_q && is_halt_word) ? S_HALT : S_IDLE;
      end
      S_HALT: if (redirect) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    halted_d   = halted_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    q_data_d   = q_data_q;
    q_pc_d     = q_pc_q;

    if (can_issue) begin
      mem_req_d  = 1'b1;
      mem_addr_d = fetch_pc_q;
    end
    if (ack_take) mem_req_d = 1'b0;

    if (redirect)  fetch_pc_d = redirect_pc;
    else if (push) fetch_pc_d = next_fetch_pc;

    // A redirect with the old request still in flight must swallow its ack.
    if (redirect && (state_q == S_WAIT) && !mem_ack) discard_d = 1'b1;
    else if (ack_take)                               discard_d = 1'b0;

    if (redirect)                  halted_d = 1'b0;
    else if (push && is_halt_word) halted_d = 1'b1;

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        q_data_d[wr_ptr_q] = mem_rdata;
        q_pc_d[wr_ptr_q]   = mem_addr_q;
        wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= ADDR_W'(RESET_PC);
      fetch_pc_q <= ADDR_W'(RESET_PC);
      discard_q  <= 1'b0;
      halted_q   <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else begin
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      halted_q   <= halted_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      q_data_q   <= q_data_d;
      q_pc_q     <= q_pc_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = (count_q != '0);
  assign instr_data  = q_data_q[rd_ptr_q];
  assign instr_pc    = q_pc_q[rd_ptr_q];
  assign halted      = halted_q;
  assign q_count     = count_q;
  assign dbg_state   = state_q;

endmodule
